// File: rtl/countdown_pkg.sv
`default_nettype none
// ============================================================================
// countdown_pkg : shared types, widths and time-step helper for the setter
// Revision      : 1.0
// ============================================================================
package countdown_pkg;

    localparam int TIME_W           = 16;
    localparam int MAX_TIME_DEFAULT = 9999;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        RUNNING = 2'd2
    } state_t;

    // Saturating single step; opposing requests in the same cycle cancel out.
    function automatic logic [TIME_W-1:0] step_time(
        input logic [TIME_W-1:0] cur,
        input logic              up,
        input logic              down,
        input logic [TIME_W-1:0] max_t
    );
        logic [TIME_W-1:0] nxt;
        nxt = cur;
        if (up && !down && (cur < max_t)) begin
            nxt = cur + 1'b1;
        end else if (down && !up && (cur != '0)) begin
            nxt = cur - 1'b1;
        end
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/countdown_time_setter_debouncer.sv
`default_nettype none
// ============================================================================
// button_debouncer : 2-FF synchronizer + counter debouncer with press pulse
// Revision         : 1.0
// ============================================================================
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        // Count consecutive disagreeing samples; any agreement restarts the count.
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule
`default_nettype wire

// File: rtl/countdown_time_setter.sv
`default_nettype none
// ============================================================================
// countdown_time_setter : button-driven seconds setter and launch control
// Revision              : 1.0
// ============================================================================
module countdown_time_setter
    import countdown_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000,
    parameter int MAX_TIME        = MAX_TIME_DEFAULT,
    parameter int DEFAULT_TIME    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              btn_start,
    input  logic              stop,
    output logic [TIME_W-1:0] time_out,
    output logic              start,
    output logic              busy
);

    localparam logic [TIME_W-1:0] MAX_T     = TIME_W'(MAX_TIME);
    localparam logic [TIME_W-1:0] DEFAULT_T = (DEFAULT_TIME > MAX_TIME) ? MAX_T
                                                                          : TIME_W'(DEFAULT_TIME);
    localparam int                HOLD_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES);
    localparam int                REP_W     = $clog2(REPEAT_CYCLES + 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES);
    localparam logic [REP_W-1:0]  REP_ONE   = REP_W'(1);

    logic up_level, up_press;
    logic down_level, down_press;
    logic start_level_unused, start_press;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_up),
        .level (up_level),
        .press (up_press)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_down),
        .level (down_level),
        .press (down_press)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_start),
        .level (start_level_unused),
        .press (start_press)
    );

    state_t            state_q, state_d;
    logic [TIME_W-1:0] time_q,  time_d;
    logic              start_q, start_d;
    logic              busy_q,  busy_d;
    logic              stop_q,  stop_d;

    logic [1:0] rep_level;
    logic [1:0] rep_fire;
    logic       up_step;
    logic       down_step;

    assign rep_level = {down_level, up_level};

    // Auto-repeat per direction: index 0 = up, index 1 = down.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_repeat
            logic [HOLD_W-1:0] hold_q, hold_d;
            logic [REP_W-1:0]  rep_q,  rep_d;
            logic              fire;

            always_comb begin
                hold_d = hold_q;
                rep_d  = rep_q;
                fire   = 1'b0;
                if (!rep_level[gi] || (state_q != IDLE)) begin
                    hold_d = '0;
                    rep_d  = '0;
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + 1'b1;
                end else if ((rep_q == '0) || (rep_q == REP_LAST)) begin
                    // rep_q==0 marks the first arrival at HOLD_CYCLES.
                    fire  = 1'b1;
                    rep_d = REP_ONE;
                end else begin
                    rep_d = rep_q + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    hold_q <= '0;
                    rep_q  <= '0;
                end else begin
                    hold_q <= hold_d;
                    rep_q  <= rep_d;
                end
            end

            assign rep_fire[gi] = fire;
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        time_d    = time_q;
        stop_d    = stop;
        up_step   = up_press   | rep_fire[0];
        down_step = down_press | rep_fire[1];

        case (state_q)
            IDLE: begin
                // A launch freezes the value, so a same-cycle step is dropped.
                if (start_press && (time_q != '0)) begin
                    state_d = LAUNCH;
                end else begin
                    time_d = step_time(time_q, up_step, down_step, MAX_T);
                end
            end
            LAUNCH: begin
                state_d = RUNNING;
            end
            RUNNING: begin
                if (stop && !stop_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        start_d = (state_d == LAUNCH);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            time_q  <= DEFAULT_T;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            stop_q  <= stop_d;
        end
    end

    assign time_out = time_q;
    assign start    = start_q;
    assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_countdown_time_setter.sv
`default_nettype none
// ============================================================================
// tb_countdown_time_setter : directed vector bench for countdown_time_setter
// Revision                 : 1.0
// ============================================================================
module tb_countdown_time_setter;

    logic        clk = 1'b0;
    logic        rst, btn_up, btn_down, btn_start, stop;
    logic [15:0] time_out, time_out_m7;
    logic        start, busy, start_m7, busy_m7;

    int n_tests    = 0;
    int n_fail     = 0;
    int start_seen = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (start === 1'b1) start_seen++;

    countdown_time_setter #(
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (20),
        .REPEAT_CYCLES   (5),
        .DEFAULT_TIME    (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_start (btn_start),
        .stop      (stop),
        .time_out  (time_out),
        .start     (start),
        .busy      (busy)
    );

    countdown_time_setter #(
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (20),
        .REPEAT_CYCLES   (5),
        .MAX_TIME        (7),
        .DEFAULT_TIME    (5)
    ) dut_m7 (
        .clk       (clk),
        .rst       (rst),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_start (btn_start),
        .stop      (stop),
        .time_out  (time_out_m7),
        .start     (start_m7),
        .busy      (busy_m7)
    );

    typedef struct {
        string name;
        logic  up;
        logic  down;
        logic  strt;
        int    hold;
        int    exp_time;
        logic  exp_busy;
        int    exp_starts;
    } vec_t;

    vec_t vecs[12];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic press_btns(input logic u, input logic d, input logic s, input int n);
        btn_up    = u;
        btn_down  = d;
        btn_start = s;
        tick(n);
        btn_up    = 1'b0;
        btn_down  = 1'b0;
        btn_start = 1'b0;
        tick(12);
    endtask

    initial begin
        int s0;

        vecs[0]  = '{"down 5->4",       1'b0, 1'b1, 1'b0,  8, 4, 1'b0, 0};
        vecs[1]  = '{"down 4->3",       1'b0, 1'b1, 1'b0,  8, 3, 1'b0, 0};
        vecs[2]  = '{"down 3->2",       1'b0, 1'b1, 1'b0,  8, 2, 1'b0, 0};
        vecs[3]  = '{"down hold to 0",  1'b0, 1'b1, 1'b0, 40, 0, 1'b0, 0};
        vecs[4]  = '{"start at 0",      1'b0, 1'b0, 1'b1,  8, 0, 1'b0, 0};
        vecs[5]  = '{"up 0->1",         1'b1, 1'b0, 1'b0,  8, 1, 1'b0, 0};
        vecs[6]  = '{"up 1->2",         1'b1, 1'b0, 1'b0,  8, 2, 1'b0, 0};
        vecs[7]  = '{"up 2->3",         1'b1, 1'b0, 1'b0,  8, 3, 1'b0, 0};
        vecs[8]  = '{"launch at 3",     1'b0, 1'b0, 1'b1,  8, 3, 1'b1, 1};
        vecs[9]  = '{"up while busy",   1'b1, 1'b0, 1'b0,  8, 3, 1'b1, 0};
        vecs[10] = '{"down while busy", 1'b0, 1'b1, 1'b0,  8, 3, 1'b1, 0};
        vecs[11] = '{"start while busy",1'b0, 1'b0, 1'b1,  8, 3, 1'b1, 0};

        rst = 1'b1; btn_up = 1'b0; btn_down = 1'b0; btn_start = 1'b0; stop = 1'b0;
        do_reset();
        check("reset time_out", time_out, 5);
        check("reset start", start, 0);
        check("reset busy", busy, 0);
        check("reset time_out max7", time_out_m7, 5);

        // Bouncing input never holds for 4 samples, then a clean hold.
        for (int i = 0; i < 6; i++) begin
            btn_up = (i % 2 == 0);
            tick(2);
        end
        check("glitch no step", time_out, 5);
        btn_up = 1'b1;
        tick(6);
        check("latency before action", time_out, 5);
        tick(1);
        check("latency at action", time_out, 6);
        tick(1);
        btn_up = 1'b0;
        tick(12);
        check("single increment", time_out, 6);

        do_reset();
        btn_up = 1'b1;
        tick(40);
        btn_up = 1'b0;
        tick(12);
        check("up hold repeat", time_out, 10);
        check("up hold saturate max7", time_out_m7, 7);

        do_reset();
        for (int i = 0; i < 12; i++) begin
            s0 = start_seen;
            press_btns(vecs[i].up, vecs[i].down, vecs[i].strt, vecs[i].hold);
            check({vecs[i].name, " time"}, time_out, vecs[i].exp_time);
            check({vecs[i].name, " busy"}, busy, vecs[i].exp_busy);
            check({vecs[i].name, " starts"}, start_seen - s0, vecs[i].exp_starts);
        end

        // Stop rises and stays high into the next run.
        stop = 1'b1;
        tick(1);
        check("stop edge busy", busy, 0);
        check("time kept after run", time_out, 3);

        s0 = start_seen;
        press_btns(1'b0, 1'b0, 1'b1, 8);
        check("relaunch busy", busy, 1);
        check("relaunch starts", start_seen - s0, 1);
        tick(10);
        check("stale stop ignored", busy, 1);
        stop = 1'b0;
        tick(3);
        check("stop low still busy", busy, 1);
        stop = 1'b1;
        tick(1);
        check("fresh stop edge", busy, 0);
        stop = 1'b0;
        tick(2);

        press_btns(1'b1, 1'b1, 1'b0, 8);
        check("up+down cancel", time_out, 3);

        press_btns(1'b0, 1'b0, 1'b1, 8);
        check("pre-reset busy", busy, 1);
        rst = 1'b1;
        tick(1);
        check("reset mid-run busy", busy, 0);
        check("reset mid-run time", time_out, 5);
        check("reset mid-run start", start, 0);
        rst = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
